fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Natural-order output stage placed directly downstream of the radix-2 SDF FFT_256 core.
- The core emits each 256-point frame in bit-reversed index order. This block buffers each frame in a ping-pong RAM and replays it in natural order k=0..N-1.
- Each frame's output is one contiguous burst of N cycles with out_valid high, which is the format the top-level bench checks.

Parameters:
- N, 256, points per frame (power of two)
- LOG2N, 8, log2(N); address width
- DW, 16, signed Q1.15 sample width per component

Ports:
- clk, input, 1, single clock; all state updates on the rising edge
- rst, input, 1, synchronous active-high reset
- in_valid, input, 1, a sample is presented this cycle; gaps between samples allowed
- in_real, input, DW, signed real part, bit-reversed order
- in_img, input, DW, signed imaginary part, bit-reversed order
- out_valid, output, 1, output sample valid
- out_real, output, DW, signed real part, natural order
- out_img, output, DW, signed imaginary part, natural order
- out_index, output, LOG2N, natural index k of the current output
- out_last, output, 1, high with k = N-1

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_real=0, out_img=0, out_index=0, out_last=0.
  - Write counter, write bank, read counter, read bank and both full flags cleared.
  - RAM contents are not cleared.
  - Reset mid-frame discards any partial frame and any pending or in-progress readout.
- Write side:
  - wr_cnt (LOG2N bits) increments on each accepted in_valid.
  - Sample is written to bank wr_bank at address bitrev(wr_cnt).
  - On the write with wr_cnt = N-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - Write never stalls; the core has no back-pressure.
  - Read rate (1/cycle) is always at least the write rate, so a target bank is never full when writing. The bench asserts this.
- Read FSM, IDLE/READ:
  - IDLE -> READ when full[rd_bank]=1 (flag sampled at the clock edge).
  - In READ, issue read address rd_cnt = 0..N-1 on consecutive cycles.
  - Synchronous RAM read; output registered one cycle later with out_valid=1 and out_index=rd_cnt.
  - When address N-1 is issued: clear full[rd_bank] and toggle rd_bank.
  - If the new rd_bank is full on that same cycle, stay in READ and restart at 0 with no bubble; otherwise go to IDLE.
- Latency:
  - If input N-1 is accepted at edge t, output k=0 is registered at edge t+2.
  - Output is N contiguous cycles regardless of input gaps.
- Back-to-back contiguous input frames produce 2N contiguous out_valid cycles.
- When out_valid=0, out_real and out_img are driven 0.
- Same-cycle set of full[A] by the writer and clear of full[B] by the reader are independent. A and B are always different banks.
- Data is passed through bit-exact; no arithmetic, rounding or saturation.

Decomposition:
- fft_pkg (shared with FFT_256 and the bench):
  - N, LOG2N, DW localparams
  - cplx_t struct {signed [DW-1:0] re, im}
  - bitrev(LOG2N-bit) function
- Sub-module fft_pingpong_ram:
  - 2*N x 2*DW simple dual-port RAM, 1 write / 1 read, synchronous read.
  - Address is {bank, idx}.
- Top level holds the write counter, the full flags, the read FSM and the output register.

Test Plan:
- Ramp: drive in_real=j, in_img=-j for j=0..255, contiguous -> k=0:(0,0), k=1:(128,-128), k=2:(64,-64), k=255:(255,-255); out_last only at k=255.
- Latency: last input accepted at edge t -> out_valid first high at edge t+2, then exactly 256 consecutive cycles, then 0.
- Back-to-back: two contiguous frames, frame 2 = ramp+1000 -> out_valid high for 512 consecutive cycles; sample 256 is (1000,-1000); no bubble at the boundary.
- Gapped input: in_valid toggling 1,0,1,0 over one ramp frame -> identical 256 outputs, contiguous, still latency 2 after the last sample.
- Reset mid-operation:
  - rst for one cycle after 100 input samples -> outputs 0 the next cycle and no out_valid.
  - A fresh full frame then reorders correctly with no residue from the aborted frame.
- Reset during readout: rst at output k=50 -> out_valid drops next edge, out_real/out_img=0; the subsequent frame is correct.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT_256 datapath, its natural-order reorder
// stage and the benches that drive them.
//   N       : points per frame (power of two)
//   LOG2N   : log2(N), width of a sample index
//   DW      : width of one signed Q1.15 component
//   cplx_t  : packed complex sample {re, im}
//   bitrev  : reverses the LOG2N bits of a sample index
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int N     = 256;
   localparam int LOG2N = 8;
   localparam int DW    = 16;

   // Index of the final sample in a frame, pre-sized so comparisons need no casts
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   // Read-side sequencer states of the reorder stage
   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

   // Mirror the index bits: bit b of the result is bit LOG2N-1-b of the input
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
      logic [LOG2N-1:0] rev;
      rev = '0;
      for (int b = 0; b < LOG2N; b++) begin
         rev[b] = idx[LOG2N-1-b];
      end
      return rev;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// ---------------------------------------------------------------------------
// fft_pingpong_ram
// Simple dual-port RAM holding two complete frames (2*N words of cplx_t).
// One write port and one synchronous read port on a single clock. The
// address is {bank, idx}, so the top bit selects the ping or pong half.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address {bank, idx}
//   wdata_i  : complex sample to store
//   re_i     : read enable; read data appears on rdata_o after the edge
//   raddr_i  : read address {bank, idx}
//   rdata_o  : registered read data
// Contents are never cleared; a reset elsewhere only abandons what is stored.
// ---------------------------------------------------------------------------
module fft_pingpong_ram
   import fft_pkg::*;
(
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [LOG2N:0]   waddr_i,
   input  cplx_t            wdata_i,
   input  logic             re_i,
   input  logic [LOG2N:0]   raddr_i,
   output cplx_t            rdata_o
);

   cplx_t mem_q [2*N];
   cplx_t rdata_q;

   // Storage array and read register share one edge. The writer and the
   // reader always work on opposite banks, so there is no read-during-write
   // hazard to resolve here.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
// Natural-order output stage for the radix-2 SDF FFT_256 core. The core emits
// each frame in bit-reversed index order; this block scatters each incoming
// sample to its natural position in one half of a ping-pong RAM, then replays
// a completed half as one contiguous N-cycle burst, k = 0..N-1.
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : a sample is presented this cycle (gaps allowed)
//   in_real    : signed real part, bit-reversed order
//   in_img     : signed imaginary part, bit-reversed order
//   out_valid  : output sample valid
//   out_real   : signed real part, natural order (0 when not valid)
//   out_img    : signed imaginary part, natural order (0 when not valid)
//   out_index  : natural index k of the current output
//   out_last   : high together with k = N-1
// Latency: last input accepted at edge t gives output k=0 at edge t+2.
// ---------------------------------------------------------------------------
module fft_bitrev_reorder
   import fft_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [DW-1:0]    in_real,
   input  logic signed [DW-1:0]    in_img,
   output logic                    out_valid,
   output logic signed [DW-1:0]    out_real,
   output logic signed [DW-1:0]    out_img,
   output logic [LOG2N-1:0]        out_index,
   output logic                    out_last
);

   // Write side
   logic [LOG2N-1:0] wr_cnt_q;
   logic             wr_bank_q;
   logic             wr_en;
   logic             wr_last;
   cplx_t            wr_data;

   // Bank-full handshake between writer and reader
   logic [1:0]       full_q;
   logic [1:0]       full_d;

   // Read side
   rd_state_e        rd_state_q;
   rd_state_e        rd_state_d;
   logic [LOG2N-1:0] rd_cnt_q;
   logic [LOG2N-1:0] rd_cnt_d;
   logic             rd_bank_q;
   logic             rd_bank_d;
   logic             rd_issue;
   logic             rd_clear;

   // Pipeline alongside the synchronous RAM read, then the output register
   cplx_t            ram_rdata;
   logic             pipe_valid_q;
   logic [LOG2N-1:0] pipe_idx_q;
   logic             out_valid_q;
   cplx_t            out_data_q;
   logic [LOG2N-1:0] out_index_q;
   logic             out_last_q;

   assign wr_en   = in_valid & ~rst;
   assign wr_last = wr_en & (wr_cnt_q == LAST_IDX);
   assign wr_data = cplx_t'{re: in_real, im: in_img};

   fft_pingpong_ram u_ram (
      .clk_i   (clk),
      .we_i    (wr_en),
      .waddr_i ({wr_bank_q, bitrev(wr_cnt_q)}),
      .wdata_i (wr_data),
      .re_i    (rd_issue),
      .raddr_i ({rd_bank_q, rd_cnt_q}),
      .rdata_o (ram_rdata)
   );

   // Writer: counts accepted samples within the frame and flips to the other
   // bank after the last one. The core cannot be stalled, so every valid
   // sample is taken unconditionally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
      end else if (in_valid) begin
         wr_cnt_q <= wr_cnt_q + LOG2N'(1);
         if (wr_cnt_q == LAST_IDX) begin
            wr_bank_q <= ~wr_bank_q;
         end
      end
   end

   // Full flags: the writer marks its bank full on the last sample, the
   // reader clears its bank when it issues the last address. The two always
   // address different banks, so the updates never collide.
   always_comb begin
      full_d = full_q;
      if (rd_clear) begin
         full_d[rd_bank_q] = 1'b0;
      end
      if (wr_last) begin
         full_d[wr_bank_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= '0;
      end else begin
         full_q <= full_d;
      end
   end

   // Read sequencer. Address 0 is already issued in the IDLE cycle that sees
   // the bank full, which is what gives the two-edge latency from the last
   // write. At the end of a bank the other bank is checked; if it is already
   // full the next burst starts on the very next cycle without a bubble. A
   // bank that only becomes full at the same edge is picked up from IDLE on
   // the following cycle, which still lines up back to back.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_bank_d  = rd_bank_q;
      rd_issue   = 1'b0;
      rd_clear   = 1'b0;

      case (rd_state_q)
         RD_IDLE: rd_issue = full_q[rd_bank_q];
         RD_READ: rd_issue = 1'b1;
         default: rd_issue = 1'b0;
      endcase

      if (rd_issue) begin
         if (rd_cnt_q == LAST_IDX) begin
            rd_clear   = 1'b1;
            rd_bank_d  = ~rd_bank_q;
            rd_cnt_d   = '0;
            rd_state_d = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
         end else begin
            rd_cnt_d   = rd_cnt_q + LOG2N'(1);
            rd_state_d = RD_READ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= RD_IDLE;
         rd_cnt_q   <= '0;
         rd_bank_q  <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_bank_q  <= rd_bank_d;
      end
   end

   // Output stage: the valid/index pipeline tracks the RAM read latency, and
   // the output register forces data to zero whenever nothing is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid_q <= 1'b0;
         pipe_idx_q   <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_index_q  <= '0;
         out_last_q   <= 1'b0;
      end else begin
         pipe_valid_q <= rd_issue;
         pipe_idx_q   <= rd_cnt_q;
         out_valid_q  <= pipe_valid_q;
         if (pipe_valid_q) begin
            out_data_q  <= ram_rdata;
            out_index_q <= pipe_idx_q;
            out_last_q  <= (pipe_idx_q == LAST_IDX);
         end else begin
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_real  = out_data_q.re;
   assign out_img   = out_data_q.im;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_reorder
// Self-checking bench for the bit-reversed to natural-order reorder stage.
// Stimulus tasks push the expected natural-order samples, each tagged with
// the clock edge it must appear on, into a scoreboard queue; an independent
// monitor pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_fft_bitrev_reorder;
   import fft_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic signed [DW-1:0] in_real;
   logic signed [DW-1:0] in_img;
   logic                 out_valid;
   logic signed [DW-1:0] out_real;
   logic signed [DW-1:0] out_img;
   logic [LOG2N-1:0]     out_index;
   logic                 out_last;

   typedef struct {
      int re;
      int im;
      int idx;
      bit last;
      int edgeNum;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   cyc      = 0;
   int   checks   = 0;
   int   errors   = 0;
   int   popCount = 0;

   fft_bitrev_reorder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_real   (in_real),
      .in_img    (in_img),
      .out_valid (out_valid),
      .out_real  (out_real),
      .out_img   (out_img),
      .out_index (out_index),
      .out_last  (out_last)
   );

   // 10 ns clock and a count of rising edges used to time-stamp expectations
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Independent index reversal: shift the input bits out LSB first
   function automatic int refBitrev(input int x);
      int r;
      r = 0;
      for (int b = 0; b < LOG2N; b++) begin
         r = (r << 1) | ((x >> b) & 1);
      end
      return r;
   endfunction

   // A ramp frame with offset base puts base+j at input position j, so
   // natural index k carries base+bitrev(k) and its negation
   task automatic pushFrame(input int base, input int startEdge);
      exp_t e;
      for (int k = 0; k < N; k++) begin
         e.re      = base + refBitrev(k);
         e.im      = -(base + refBitrev(k));
         e.idx     = k;
         e.last    = (k == N - 1);
         e.edgeNum = startEdge + k;
         expQ.push_back(e);
      end
   endtask

   // Drive one ramp frame; with gapped set every sample is followed by an
   // idle cycle. The last sample is accepted at edge cyc+1, so output k=0
   // must be registered at edge cyc+3.
   task automatic applyStimulus(input int base, input bit gapped);
      for (int j = 0; j < N; j++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_real  = DW'(base + j);
         in_img   = DW'(-(base + j));
         if (j == N - 1) pushFrame(base, cyc + 3);
         if (gapped) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_real  = '0;
         in_img   = '0;
      end
   endtask

   // Explicit check that the outputs sit at their cleared values
   task automatic checkOutput(input string name);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_real !== '0 || out_img !== '0 ||
          out_index !== '0 || out_last !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s: got valid=%0b re=%0d im=%0d idx=%0d last=%0b, required all 0",
                  name, out_valid, out_real, out_img, out_index, out_last);
      end
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (expQ.size() > 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d samples still pending, required 0",
                  expQ.size());
         expQ.delete();
      end
   endtask

   // Monitor: every valid output must match the head of the scoreboard,
   // including the edge it lands on; idle cycles must carry zero data and
   // must not hide an overdue expected sample.
   always @(negedge clk) begin
      if (out_valid) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_output: got valid sample k=%0d re=%0d at edge %0d, required none",
                     out_index, out_real, cyc);
         end else begin
            monE = expQ.pop_front();
            popCount++;
            if (int'(out_real) != monE.re || int'(out_img) != monE.im ||
                int'(out_index) != monE.idx || out_last != monE.last ||
                cyc != monE.edgeNum) begin
               errors++;
               $display("[TB] FAIL sample_k%0d: got edge=%0d re=%0d im=%0d idx=%0d last=%0b, required edge=%0d re=%0d im=%0d idx=%0d last=%0b",
                        monE.idx, cyc, out_real, out_img, out_index, out_last,
                        monE.edgeNum, monE.re, monE.im, monE.idx, monE.last);
            end
         end
      end else begin
         checks++;
         if (out_real !== '0 || out_img !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_zero: got re=%0d im=%0d last=%0b at edge %0d, required 0",
                     out_real, out_img, out_last, cyc);
         end
         if (expQ.size() > 0) begin
            checks++;
            if (expQ[0].edgeNum <= cyc) begin
               errors++;
               $display("[TB] FAIL missing_output: got out_valid=0 at edge %0d, required k=%0d due at edge %0d",
                        cyc, expQ[0].idx, expQ[0].edgeNum);
               void'(expQ.pop_front());
            end
         end
      end
   end

   // The writer must never land on a bank the reader still owns
   always @(posedge clk) begin
      if (!rst && in_valid) begin
         checks++;
         if (dut.full_q[dut.wr_bank_q]) begin
            errors++;
            $display("[TB] FAIL write_into_full: got write to full bank %0d at edge %0d, required bank empty",
                     dut.wr_bank_q, cyc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int target;
      int n;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_real  = '0;
      in_img   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("reset_state");

      $display("[TB] ramp frame");
      applyStimulus(0, 1'b0);
      idleCycles(1);
      waitDrain(600);
      idleCycles(5);

      $display("[TB] back-to-back frames");
      applyStimulus(0, 1'b0);
      applyStimulus(1000, 1'b0);
      idleCycles(1);
      waitDrain(1000);
      idleCycles(5);

      $display("[TB] gapped frame");
      applyStimulus(0, 1'b1);
      idleCycles(1);
      waitDrain(600);
      idleCycles(5);

      $display("[TB] reset after 100 input samples");
      for (int j = 0; j < 100; j++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_real  = DW'(500 + j);
         in_img   = DW'(-(500 + j));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_mid_input");
      applyStimulus(2000, 1'b0);
      idleCycles(1);
      waitDrain(600);
      idleCycles(5);

      $display("[TB] reset during readout");
      applyStimulus(0, 1'b0);
      idleCycles(1);
      target = popCount + 51;
      n = 0;
      while (popCount < target && n < 1000) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (popCount < target) begin
         errors++;
         $display("[TB] FAIL readout_k50_timeout: got %0d outputs, required %0d",
                  popCount, target);
      end
      rst = 1'b1;
      expQ.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_mid_readout");
      idleCycles(3);
      applyStimulus(3000, 1'b0);
      idleCycles(1);
      waitDrain(600);
      idleCycles(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
